prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 27 ++
 rtl/uart_rx.sv | 107 ++++++++++
 rtl/prog_loader.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encodings and sizing constants for the
// serial program loader and its UART receiver.
package prog_loader_pkg;

  // Default bit period: 50 MHz clock at 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // Image length is carried in 9 bits so that a length byte of 0 can mean 256.
  localparam int LEN_W = 9;

  // Loader FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CKSUM = 2'd2,
    ST_RUN   = 2'd3
  } ld_state_t;

  // Receiver FSM states.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1, LSB-first UART receiver. Synchronises rxd, qualifies the
// start bit at its centre, samples data and stop bits at bit centres and
// reports either a good byte (rx_valid) or a framing error (rx_ferr).
module uart_rx
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

  logic            sync1_q, sync2_q, prev_q;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  // Synchroniser, edge-history flop and receiver state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Bit timing, start qualification, shifting and stop-bit check.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          bit_d = '0;
          // A line that is high again mid start bit was a glitch.
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = RX_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_CNT) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_valid = valid_q;
  assign rx_byte  = shift_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/prog_loader.sv
// prog_loader: holds the CPU in stall while a length-prefixed program image
// arrives over the UART and is written into program RAM, then hands the RAM
// port to the CPU. Optional trailing checksum: define PROG_LOADER_CKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  input  logic [7:0] cpu_adrs,
  input  logic [7:0] cpu_data,
  input  logic       cpu_wr_en,
  output logic [7:0] ram_adrs,
  output logic [7:0] ram_data,
  output logic       ram_wr_en,
  output logic       cpu_hold,
  output logic       load_done,
  output logic       load_err
);

  logic       rx_valid, rx_ferr;
  logic [7:0] rx_byte;

  ld_state_t        state_q, state_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             err_q, err_d;
  logic             wr_q, wr_d;
  logic [7:0]       wadr_q, wadr_d;
  logic [7:0]       wdat_q, wdat_d;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]       sum_q, sum_d;
`endif
  logic             run;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock    (clock),
    .reset    (reset),
    .rxd      (rxd),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .rx_ferr  (rx_ferr)
  );

  // Loader state, image progress and the registered RAM write port.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
      wadr_q  <= '0;
      wdat_q  <= '0;
`ifdef PROG_LOADER_CKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      wadr_q  <= wadr_d;
      wdat_q  <= wdat_d;
`ifdef PROG_LOADER_CKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Next-state logic: length capture, payload writes, completion check.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    err_d   = err_q;
    wr_d    = 1'b0;
    wadr_d  = wadr_q;
    wdat_d  = wdat_q;
`ifdef PROG_LOADER_CKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          len_d   = (rx_byte == 8'h00) ? LEN_W'(256) : {1'b0, rx_byte};
          count_d = '0;
          err_d   = 1'b0;
          state_d = ST_DATA;
`ifdef PROG_LOADER_CKSUM_EN
          sum_d   = '0;
`endif
        end else if (rx_ferr) begin
          err_d = 1'b1;
        end
      end
      ST_DATA: begin
        // Completion is checked one cycle after the last write so the final
        // write pulse still goes out through the loader-owned RAM port.
        if (count_q == len_q) begin
`ifdef PROG_LOADER_CKSUM_EN
          state_d = ST_CKSUM;
`else
          state_d = ST_RUN;
`endif
        end else if (rx_valid) begin
          wr_d    = 1'b1;
          wadr_d  = count_q[7:0];
          wdat_d  = rx_byte;
          count_d = count_q + 1'b1;
`ifdef PROG_LOADER_CKSUM_EN
          sum_d   = sum_q + rx_byte;
`endif
        end else if (rx_ferr) begin
          err_d = 1'b1;
        end
      end
`ifdef PROG_LOADER_CKSUM_EN
      ST_CKSUM: begin
        if (rx_valid) begin
          if (rx_byte == sum_q) begin
            state_d = ST_RUN;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
`endif
      ST_RUN: ;
      default: state_d = ST_IDLE;
    endcase
  end

  assign run       = (state_q == ST_RUN);
  assign cpu_hold  = !run;
  assign load_done = run;
  assign load_err  = err_q;
  assign ram_adrs  = run ? cpu_adrs  : wadr_q;
  assign ram_data  = run ? cpu_data  : wdat_q;
  assign ram_wr_en = run ? cpu_wr_en : wr_q;

endmodule
